// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Receive-side decoder for a multiplexed 8-digit, active-low seven-segment
//   bus. It samples the cathode/anode buses once per stable digit period and
//   rebuilds the 32-bit hex value being shown.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   cat_in[6:0]     cathodes, active-low (bit0 = seg a ... bit6 = seg g)
//   an_in[7:0]      anodes, active-low (bit k selects digit k / nibble k)
//   val_out[31:0]   last complete reconstructed value
//   valid_out       one-cycle pulse when val_out updates
//   error_out       one-cycle pulse on a malformed sample
//   digit_mask_out  digits captured so far in the current frame
module seven_segment_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [6:0]  cat_in,
  input  logic [7:0]  an_in,
  output logic [31:0] val_out,
  output logic        valid_out,
  output logic        error_out,
  output logic [7:0]  digit_mask_out
);

  localparam logic [15:0] SETTLE    = 16'(SETTLE_CYCLES);
  localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_CYCLES - 1);

  // {valid, nibble} for an active-high segment pattern
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // {an, cat} synchronizer, preset to all-ones (everything off)
  logic [14:0] sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] val_q, val_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  logic        stable;
  logic        sample;
  logic [7:0]  act_an;
  logic [6:0]  act_seg;
  logic [4:0]  glyph;
  logic        one_hot;
  logic [2:0]  digit_idx;
  logic        capture;
  logic        bad;
  logic        frame_done;

  always_comb begin
    stable     = (sync2_q == prev_q);
    // counter sits at SETTLE_M1 for exactly one stable cycle, then saturates
    sample     = stable && (cnt_q == SETTLE_M1);
    act_an     = ~sync2_q[14:7];
    act_seg    = ~sync2_q[6:0];
    glyph      = glyph_decode(act_seg);
    one_hot    = (act_an != 8'h00) && ((act_an & (act_an - 8'd1)) == 8'h00);
    digit_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (act_an[i]) digit_idx = 3'(i);
    end
    capture    = sample && one_hot && glyph[4];
    // blanked display (no anode) is idle, not an error
    bad        = sample && (act_an != 8'h00) && !(one_hot && glyph[4]);
    frame_done = (mask_q == 8'hFF);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!stable) begin
      cnt_d = 16'd0;
    end else if (cnt_q != SETTLE) begin
      cnt_d = cnt_q + 16'd1;
    end

    shadow_d = shadow_q;
    mask_d   = frame_done ? 8'h00 : mask_q;
    if (capture) begin
      shadow_d[{digit_idx, 2'b00} +: 4] = glyph[3:0];
      mask_d[digit_idx]                 = 1'b1;
    end

    // shadow already holds the completing capture by the time mask reads full
    val_d   = frame_done ? shadow_q : val_q;
    valid_d = frame_done;
    error_d = bad;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      val_q    <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      sync1_q  <= {an_in, cat_in};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      val_q    <= val_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign val_out        = val_q;
  assign valid_out      = valid_q;
  assign error_out      = error_q;
  assign digit_mask_out = mask_q;

endmodule
